// File: rtl/result_accumulator_if.sv
// Bus bundle for result_accumulator: the upstream sample strobe, the
// downstream valid/ready total, and the overflow and occupancy status.
interface result_accumulator_if #(
    parameter int W          = 8,
    parameter int N          = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int SW = W + $clog2(N);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_ready;
    logic          clear_ovf;
    logic          out_valid;
    logic [SW-1:0] out_sum;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    // The producer/consumer side drives samples and ready, and observes results.
    modport master (
        output in_valid, in_data, out_ready, clear_ovf,
        input  out_valid, out_sum, overflow, fifo_level
    );

    // The accumulator side consumes samples and ready, and drives results.
    modport slave (
        input  in_valid, in_data, out_ready, clear_ovf,
        output out_valid, out_sum, overflow, fifo_level
    );
endinterface

// File: rtl/result_accumulator.sv
// Buffers the adder's result stream in a small FIFO and sums each group of
// N consecutive samples into a wider total, presented on valid/ready.
// Upstream cannot be stalled, so samples arriving at a full FIFO are
// dropped and a sticky overflow flag is raised.
module result_accumulator #(
    parameter int W          = 8,
    parameter int N          = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    result_accumulator_if.slave  bus
);
    localparam int SW = W + $clog2(N);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(N);

    typedef enum logic {ACC, HOLD} state_t;

    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] out_sum_q, out_sum_d;
    logic          out_valid_q, out_valid_d;
    logic          overflow_q, overflow_d;
    state_t        state_q, state_d;

    logic          full, empty, push, drop, pop, last;
    logic [W-1:0]  head;
    logic [SW-1:0] sum;

    // Full/drop decisions use the registered level, so a same-cycle pop
    // never makes room for an incoming sample.
    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign push  = bus.in_valid && !full;
    assign drop  = bus.in_valid && full;
    assign pop   = (state_q == ACC) && !empty;
    assign last  = (cnt_q == CW'(N - 1));
    assign head  = mem_q[rptr_q];
    assign sum   = acc_q + SW'(head);

    // Group accumulation FSM: pop and add in ACC, present the total in HOLD.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ACC: begin
                if (pop) begin
                    if (last) begin
                        out_sum_d   = sum;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                // No pop in the handshake cycle; popping resumes next cycle.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // Occupancy and sticky overflow; a drop outranks a simultaneous clear.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        overflow_d = overflow_q;
        if (drop)               overflow_d = 1'b1;
        else if (bus.clear_ovf) overflow_d = 1'b0;
    end

    // Control and datapath state; reset discards partial groups and buffered samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            level_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            level_q     <= level_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // FIFO storage; contents need no reset since the level gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= bus.in_data;
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_sum    = out_sum_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_result_accumulator.sv
// Directed bench for result_accumulator with a scoreboard of expected totals.
module tb_result_accumulator;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;
    int unsigned sb[$];
    logic vld_seen = 1'b0;

    result_accumulator_if #(.W(W), .N(N), .FIFO_DEPTH(FD)) bus ();

    result_accumulator #(.W(W), .N(N), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Scoreboard: compare each newly presented total against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && !vld_seen) begin
                vld_seen = 1'b1;
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) check("sb_out_sum", 32'(bus.out_sum), sb.pop_front());
            end
            if (!bus.out_valid) vld_seen = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v [8];
        int unsigned s0, s1;
        int waited;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.clear_ovf = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_sum",   32'(bus.out_sum), 0);
        check("rst_overflow",  32'(bus.overflow), 0);
        check("rst_level",     32'(bus.fifo_level), 0);
        tick();
        rst = 1'b0;

        // Basic group with latency check
        bus.out_ready = 1'b1;
        sb.push_back(10);
        push(1); push(2); push(3); push(4);
        check("lat_pre_valid", 32'(bus.out_valid), 0);
        tick();
        check("lat_valid", 32'(bus.out_valid), 1);
        check("lat_sum",   32'(bus.out_sum), 10);
        tick();
        check("lat_valid_fall", 32'(bus.out_valid), 0);
        repeat (3) tick();
        check("lvl_drained", 32'(bus.fifo_level), 0);

        // Max-value samples, no wrap
        sb.push_back(1020);
        repeat (4) push(8'd255);
        repeat (6) tick();
        check("max_no_ovf", 32'(bus.overflow), 0);

        // Backpressure: fill FIFO while HOLD, fifth sample dropped
        bus.out_ready = 1'b0;
        sb.push_back(10);
        push(1); push(2); push(3); push(4);
        tick();
        sb.push_back(36);
        repeat (5) push(8'd9);
        check("bp_level",    32'(bus.fifo_level), 4);
        check("bp_overflow", 32'(bus.overflow), 1);
        check("bp_hold_sum", 32'(bus.out_sum), 10);
        check("bp_hold_vld", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        repeat (5) tick();
        check("bp_sum36_vld", 32'(bus.out_valid), 1);
        check("bp_sum36",     32'(bus.out_sum), 36);
        tick();
        check("ovf_sticky", 32'(bus.overflow), 1);

        // Clear semantics: plain clear, drop beats clear, plain clear again
        bus.clear_ovf = 1'b1;
        tick();
        bus.clear_ovf = 1'b0;
        check("ovf_cleared", 32'(bus.overflow), 0);
        bus.out_ready = 1'b0;
        sb.push_back(4);
        repeat (4) push(8'd1);
        tick();
        sb.push_back(8);
        repeat (4) push(8'd2);
        check("clr_full", 32'(bus.fifo_level), 4);
        bus.clear_ovf = 1'b1;
        push(8'd2);
        bus.clear_ovf = 1'b0;
        check("clr_drop_wins", 32'(bus.overflow), 1);
        bus.clear_ovf = 1'b1;
        tick();
        bus.clear_ovf = 1'b0;
        check("clr_no_drop", 32'(bus.overflow), 0);
        bus.out_ready = 1'b1;
        repeat (14) tick();
        check("clr_drained", 32'(bus.fifo_level), 0);

        // Reset mid-group discards the partial sum
        push(5); push(6);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        check("mid_rst_sum",   32'(bus.out_sum), 0);
        check("mid_rst_ovf",   32'(bus.overflow), 0);
        check("mid_rst_level", 32'(bus.fifo_level), 0);
        tick();
        rst = 1'b0;
        sb.push_back(4);
        repeat (4) push(8'd1);
        tick();
        check("post_rst_sum", 32'(bus.out_sum), 4);
        tick();

        // Continuous stream, two groups back to back
        s0 = 0; s1 = 0;
        for (int i = 0; i < 8; i++) begin
            v[i] = 8'($urandom_range(0, 255));
            if (i < 4) s0 += v[i]; else s1 += v[i];
        end
        sb.push_back(s0);
        sb.push_back(s1);
        for (int i = 0; i < 8; i++) begin
            push(v[i]);
            check("cont_level_le2", 32'(bus.fifo_level <= 2), 1);
        end
        repeat (8) tick();
        check("cont_no_ovf", 32'(bus.overflow), 0);

        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            tick();
            waited++;
        end
        check("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
